// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo
//   Buffered UART transmitter for the host link. Bytes written by the core
//   are queued in a circular FIFO. They are then sent on tx as 8N1 frames,
//   LSB first. Frames are sent back to back with no idle gap while bytes
//   remain queued.
//
//   Optional build macro: UART_TX_PARITY_EN
//     When defined, an even-parity bit is inserted between the last data bit
//     and the stop bit, which gives an 8E1 frame. The port list is the same
//     in both builds.
//
// Ports
//   clk     in   system clock, rising edge
//   rst_n   in   asynchronous active-low reset
//   we      in   write strobe from the core
//   w_data  in   byte to queue, sampled when we=1
//   full    out  FIFO full; writes are dropped while high
//   empty   out  no queued bytes (the byte on the wire is not counted)
//   count   out  number of queued bytes, 0..FIFO_DEPTH
//   busy    out  a frame is on the wire (FSM not IDLE)
//   tx      out  serial line, idle high, registered
//
// FSM states
//   state    | meaning
//   S_IDLE   | line idle high, waiting for a queued byte
//   S_START  | start bit (low) for CLKS_PER_BIT cycles
//   S_DATA   | payload bits, LSB first, CLKS_PER_BIT cycles each
//   S_PARITY | even-parity bit (UART_TX_PARITY_EN builds only)
//   S_STOP   | stop bit (high); chains straight into S_START if more is queued
module uart_tx_fifo #(
  parameter int FIFO_DEPTH      = 256,
  parameter int FIFO_DATA_WIDTH = 8,
  parameter int CLKS_PER_BIT    = 868
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          we,
  input  logic [FIFO_DATA_WIDTH-1:0]    w_data,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          busy,
  output logic                          tx
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W  = (FIFO_DATA_WIDTH > 1) ? $clog2(FIFO_DATA_WIDTH) : 1;

  localparam logic [PTR_W:0]    PTR_ONE   = 1;
  localparam logic [BAUD_W-1:0] BAUD_ONE  = 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  BIT_ONE   = 1;
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(FIFO_DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  logic [FIFO_DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W:0]             r_wptr;
  logic [PTR_W:0]             r_rptr;
  state_t                     r_state;
  logic [BAUD_W-1:0]          r_baud_cnt;
  logic [BIT_W-1:0]           r_bit_idx;
  logic [FIFO_DATA_WIDTH-1:0] r_shift;
  logic                       r_tx;
  logic                       r_busy;
`ifdef UART_TX_PARITY_EN
  logic                       r_parity;
`endif

  logic                       w_empty;
  logic                       w_full;
  logic                       w_push;
  logic                       w_baud_done;
  logic [FIFO_DATA_WIDTH-1:0] w_head;
  logic [FIFO_DATA_WIDTH-1:0] w_shift_nxt;

  // Pointers carry one extra MSB so that full and empty can be told apart
  // when the slot indices are equal.
  assign w_empty     = (r_wptr == r_rptr);
  assign w_full      = (r_wptr[PTR_W] != r_rptr[PTR_W]) &&
                       (r_wptr[PTR_W-1:0] == r_rptr[PTR_W-1:0]);
  assign w_push      = we && !w_full;
  assign w_head      = r_mem[r_rptr[PTR_W-1:0]];
  assign w_shift_nxt = r_shift >> 1;
  assign w_baud_done = (r_baud_cnt == '0);

  assign full  = w_full;
  assign empty = w_empty;
  assign count = r_wptr - r_rptr;
  assign busy  = r_busy;
  assign tx    = r_tx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
    end else if (w_push) begin
      r_wptr <= r_wptr + PTR_ONE;
    end
  end

  // Storage is not reset; only slots between the pointers are ever read.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr[PTR_W-1:0]] <= w_data;
    end
  end

  // The baud counter counts down from CLKS_PER_BIT-1. Every bit period ends
  // on its terminal count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_rptr     <= '0;
      r_baud_cnt <= '0;
      r_bit_idx  <= '0;
      r_shift    <= '0;
      r_tx       <= 1'b1;
      r_busy     <= 1'b0;
`ifdef UART_TX_PARITY_EN
      r_parity   <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          r_tx <= 1'b1;
          if (!w_empty) begin
            r_shift    <= w_head;
`ifdef UART_TX_PARITY_EN
            r_parity   <= ^w_head;
`endif
            r_rptr     <= r_rptr + PTR_ONE;
            r_tx       <= 1'b0;
            r_baud_cnt <= BAUD_LAST;
            r_busy     <= 1'b1;
            r_state    <= S_START;
          end
        end

        S_START: begin
          if (w_baud_done) begin
            r_tx       <= r_shift[0];
            r_bit_idx  <= '0;
            r_baud_cnt <= BAUD_LAST;
            r_state    <= S_DATA;
          end else begin
            r_baud_cnt <= r_baud_cnt - BAUD_ONE;
          end
        end

        S_DATA: begin
          if (w_baud_done) begin
            r_baud_cnt <= BAUD_LAST;
            if (r_bit_idx == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
              r_tx    <= r_parity;
              r_state <= S_PARITY;
`else
              r_tx    <= 1'b1;
              r_state <= S_STOP;
`endif
            end else begin
              r_shift   <= w_shift_nxt;
              r_tx      <= w_shift_nxt[0];
              r_bit_idx <= r_bit_idx + BIT_ONE;
            end
          end else begin
            r_baud_cnt <= r_baud_cnt - BAUD_ONE;
          end
        end

`ifdef UART_TX_PARITY_EN
        S_PARITY: begin
          if (w_baud_done) begin
            r_tx       <= 1'b1;
            r_baud_cnt <= BAUD_LAST;
            r_state    <= S_STOP;
          end else begin
            r_baud_cnt <= r_baud_cnt - BAUD_ONE;
          end
        end
`endif

        S_STOP: begin
          if (w_baud_done) begin
            // Pop here instead of in IDLE so that back-to-back frames
            // have no idle gap between them.
            if (!w_empty) begin
              r_shift    <= w_head;
`ifdef UART_TX_PARITY_EN
              r_parity   <= ^w_head;
`endif
              r_rptr     <= r_rptr + PTR_ONE;
              r_tx       <= 1'b0;
              r_baud_cnt <= BAUD_LAST;
              r_state    <= S_START;
            end else begin
              r_tx    <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= S_IDLE;
            end
          end else begin
            r_baud_cnt <= r_baud_cnt - BAUD_ONE;
          end
        end

        default: begin
          r_tx    <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo, built with a 4-deep FIFO and 4 clocks per bit.
// Expected bytes go into a scoreboard queue when they are written and are
// compared when a frame is decoded from tx.
`timescale 1ns/1ps
module tb_uart_tx_fifo;
  localparam int DEPTH = 4;
  localparam int DW    = 8;
  localparam int CPB   = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = DW + 3;
`else
  localparam int NBITS = DW + 2;
`endif
  localparam int FRAME = NBITS * CPB;

  logic                     clk = 1'b0;
  logic                     rst_n = 1'b1;
  logic                     we = 1'b0;
  logic [DW-1:0]            w_data = '0;
  logic                     full, empty, busy, tx;
  logic [$clog2(DEPTH):0]   count;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] sb[$];
  logic [DW-1:0] rx_q[$];
  int            gap_q[$];
  int            mon_bad;
  bit            mon_timeout;

  uart_tx_fifo #(
    .FIFO_DEPTH(DEPTH), .FIFO_DATA_WIDTH(DW), .CLKS_PER_BIT(CPB)
  ) dut (
    .clk(clk), .rst_n(rst_n), .we(we), .w_data(w_data),
    .full(full), .empty(empty), .count(count), .busy(busy), .tx(tx)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference line level k cycles after the start bit begins.
  function automatic logic exp_tx(input logic [DW-1:0] d, input int k);
    int b;
    b = k / CPB;
    if (b == 0) return 1'b0;
    if (b <= DW) return d[b-1];
`ifdef UART_TX_PARITY_EN
    if (b == DW + 1) return ^d;
`endif
    return 1'b1;
  endfunction

  // Decodes n frames from tx into rx_q. It records the idle cycles between
  // frames in gap_q and counts glitches and framing faults in mon_bad.
  task automatic collect_frames(input int n, input int budget);
    int            wait_c;
    logic [DW-1:0] d;
    logic [NBITS-1:0] bits;
    mon_timeout = 1'b0;
    mon_bad = 0;
    for (int f = 0; f < n; f++) begin
      wait_c = 0;
      while (tx !== 1'b0 && wait_c < budget) begin
        step();
        wait_c++;
      end
      if (tx !== 1'b0) begin
        mon_timeout = 1'b1;
        return;
      end
      if (f > 0) gap_q.push_back(wait_c);
      bits = '0;
      for (int k = 0; k < FRAME; k++) begin
        if (k % CPB == 0) bits[k/CPB] = tx;
        else if (tx !== bits[k/CPB]) mon_bad++;
        step();
      end
      d = bits[DW:1];
      if (bits[0] !== 1'b0 || bits[NBITS-1] !== 1'b1) mon_bad++;
`ifdef UART_TX_PARITY_EN
      if (bits[DW+1] !== ^d) mon_bad++;
`endif
      rx_q.push_back(d);
    end
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    we = 1'b0;
    repeat (3) step();
    checks++;
    if ({tx, busy, empty, full, count} !== {1'b1, 1'b0, 1'b1, 1'b0, 3'd0}) begin
      errors++;
      $display("FAIL reset_state: tx/busy/empty/full/count = %b %b %b %b %0d, want 1 0 1 0 0",
               tx, busy, empty, full, count);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 100; i++) begin
      step();
      checks++;
      if ({tx, busy, empty, full, count} !== {1'b1, 1'b0, 1'b1, 1'b0, 3'd0}) begin
        errors++;
        $display("FAIL idle_after_reset cycle %0d: tx/busy/empty/full/count = %b %b %b %b %0d, want 1 0 1 0 0",
                 i, tx, busy, empty, full, count);
      end
    end
  endtask

  task automatic test_single(input logic [DW-1:0] d);
    logic [DW-1:0] rxd;
    logic [DW-1:0] exp;
    rxd = '0;
    sb.push_back(d);
    we = 1'b1;
    w_data = d;
    step();
    we = 1'b0;
    w_data = ~d;
    checks++;
    if (empty !== 1'b0 || count !== 3'd1 || tx !== 1'b1) begin
      errors++;
      $display("FAIL single_after_write 0x%02h: empty=%b count=%0d tx=%b, want 0 1 1", d, empty, count, tx);
    end
    step();
    checks++;
    if (empty !== 1'b1 || busy !== 1'b1 || count !== 3'd0) begin
      errors++;
      $display("FAIL single_pop 0x%02h: empty=%b busy=%b count=%0d, want 1 1 0", d, empty, busy, count);
    end
    for (int k = 0; k < FRAME; k++) begin
      if (k % CPB == CPB / 2 && k / CPB >= 1 && k / CPB <= DW) rxd[k/CPB-1] = tx;
      checks++;
      if (tx !== exp_tx(d, k) || busy !== 1'b1) begin
        errors++;
        $display("FAIL single_wave 0x%02h cycle %0d: tx=%b busy=%b, want tx=%b busy=1",
                 d, k, tx, busy, exp_tx(d, k));
      end
      step();
    end
    checks++;
    if (busy !== 1'b0 || tx !== 1'b1) begin
      errors++;
      $display("FAIL single_end 0x%02h: busy=%b tx=%b, want 0 1", d, busy, tx);
    end
    exp = sb.pop_front();
    checks++;
    if (rxd !== exp) begin
      errors++;
      $display("FAIL single_byte: got 0x%02h, want 0x%02h", rxd, exp);
    end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] exp;
    rx_q.delete();
    gap_q.delete();
    sb.push_back(8'h00);
    we = 1'b1;
    w_data = 8'h00;
    step();
    sb.push_back(8'hFF);
    w_data = 8'hFF;
    checks++;
    if (count !== 3'd1 || tx !== 1'b1) begin
      errors++;
      $display("FAIL b2b_first_write: count=%0d tx=%b, want 1 1", count, tx);
    end
    step();
    we = 1'b0;
    checks++;
    if (count !== 3'd1 || tx !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_pop_and_write: count=%0d tx=%b busy=%b, want 1 0 1", count, tx, busy);
    end
    collect_frames(2, 2 * FRAME);
    checks++;
    if (mon_timeout || mon_bad != 0 || rx_q.size() != 2 || gap_q.size() != 1) begin
      errors++;
      $display("FAIL b2b_frames: timeout=%0d bad=%0d frames=%0d, want 0 0 2", mon_timeout, mon_bad, rx_q.size());
    end else begin
      checks++;
      if (gap_q[0] != 0) begin
        errors++;
        $display("FAIL b2b_gap: %0d idle cycles, want 0", gap_q[0]);
      end
      for (int i = 0; i < 2; i++) begin
        exp = sb.pop_front();
        checks++;
        if (rx_q[i] !== exp) begin
          errors++;
          $display("FAIL b2b_byte %0d: got 0x%02h, want 0x%02h", i, rx_q[i], exp);
        end
      end
    end
    sb.delete();
  endtask

  task automatic test_fill();
    int m_count;
    logic [DW-1:0] exp;
    bit acc;
    rx_q.delete();
    gap_q.delete();
    m_count = 0;
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          we = 1'b1;
          w_data = DW'(i + 1);
          acc = (m_count < DEPTH);
          if (acc) sb.push_back(DW'(i + 1));
          step();
          if (acc) m_count++;
          if (i == 1) m_count--;
          checks++;
          if (count !== 3'(m_count) || full !== (m_count == DEPTH)) begin
            errors++;
            $display("FAIL fill_write %0d: count=%0d full=%b, want %0d %b",
                     i + 1, count, full, m_count, (m_count == DEPTH));
          end
        end
        we = 1'b0;
      end
      begin
        collect_frames(5, 3 * FRAME);
      end
    join
    checks++;
    if (mon_timeout || mon_bad != 0 || rx_q.size() != 5) begin
      errors++;
      $display("FAIL fill_frames: timeout=%0d bad=%0d frames=%0d, want 0 0 5", mon_timeout, mon_bad, rx_q.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        exp = sb.pop_front();
        checks++;
        if (rx_q[i] !== exp) begin
          errors++;
          $display("FAIL fill_byte %0d: got 0x%02h, want 0x%02h", i, rx_q[i], exp);
        end
      end
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (gap_q[i] != 0) begin
          errors++;
          $display("FAIL fill_gap %0d: %0d idle cycles, want 0", i, gap_q[i]);
        end
      end
    end
    for (int i = 0; i < 2 * FRAME; i++) begin
      checks++;
      if (tx !== 1'b1 || busy !== 1'b0 || empty !== 1'b1) begin
        errors++;
        $display("FAIL fill_no_extra cycle %0d: tx=%b busy=%b empty=%b, want 1 0 1", i, tx, busy, empty);
      end
      step();
    end
    sb.delete();
  endtask

  task automatic test_reset_mid();
    we = 1'b1;
    w_data = 8'h3C;
    step();
    w_data = 8'h11;
    step();
    w_data = 8'h22;
    step();
    we = 1'b0;
    // The start bit began one edge after the 0x3C write. Data bit 3 is
    // cycles 16..19 of the frame.
    repeat (16) step();
    checks++;
    if (tx !== exp_tx(8'h3C, 17) || busy !== 1'b1 || count !== 3'd2) begin
      errors++;
      $display("FAIL mid_before_reset: tx=%b busy=%b count=%0d, want %b 1 2", tx, busy, count, exp_tx(8'h3C, 17));
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({tx, busy, empty, full, count} !== {1'b1, 1'b0, 1'b1, 1'b0, 3'd0}) begin
      errors++;
      $display("FAIL mid_async_reset: tx/busy/empty/full/count = %b %b %b %b %0d, want 1 0 1 0 0",
               tx, busy, empty, full, count);
    end
    step();
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 2 * FRAME + 8; i++) begin
      step();
      checks++;
      if (tx !== 1'b1 || busy !== 1'b0 || count !== 3'd0) begin
        errors++;
        $display("FAIL mid_after_release cycle %0d: tx=%b busy=%b count=%0d, want 1 0 0", i, tx, busy, count);
      end
    end
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity();
    logic pat [11];
    pat = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    we = 1'b1;
    w_data = 8'h07;
    step();
    we = 1'b0;
    step();
    for (int k = 0; k < 44; k++) begin
      checks++;
      if (tx !== pat[k/4] || busy !== 1'b1) begin
        errors++;
        $display("FAIL parity_wave cycle %0d: tx=%b busy=%b, want tx=%b busy=1", k, tx, busy, pat[k/4]);
      end
      step();
    end
    checks++;
    if (busy !== 1'b0 || tx !== 1'b1) begin
      errors++;
      $display("FAIL parity_end: busy=%b tx=%b, want 0 1", busy, tx);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single(8'hA5);
    test_single(8'h01);
    test_back_to_back();
    test_fill();
    test_reset_mid();
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

endmodule
